vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; next generation of the 640x480 VGA controller.
//  Runs entirely in the clk_100MHz domain, using a pixel clock-enable (no derived clocks).
//  Adds the following over the fixed controller:
//    - configurable divider, porches and sync polarity
//    - run enable
//    - line/frame strobes, vblank and a frame counter
//  Feeds the pixel/image generators and the VGA pins.
// PARAMETERS
//  CLK_DIV    4    clk_100MHz cycles per pixel; >=1 (1 => p_tick=en)
//  HD         640  horizontal display pixels
//  HF         16   horizontal front porch
//  HS         96   horizontal sync width
//  HB         48   horizontal back porch
//  VD         480  vertical display lines
//  VF         10   vertical front porch
//  VS         2    vertical sync width
//  VB         33   vertical back porch
//  HSYNC_POL  0    active level of hsync (0 = active-low)
//  VSYNC_POL  0    active level of vsync
//  CW         10   x/y counter width; elaboration error if HD+HF+HS+HB > 2**CW (same for V)
//  FCW        16   frame counter width
// PORTS
//  clk_100MHz   in   1    system clock, 100 MHz
//  reset_n      in   1    asynchronous, active-low reset
//  en           in   1    1 = run; 0 = freeze divider, counters and outputs
//  p_tick       out  1    pixel enable; (div==CLK_DIV-1) && en, combinational
//  x            out  CW   registered horizontal position, 0..HTOT-1
//  y            out  CW   registered vertical position, 0..VTOT-1
//  video_on     out  1    registered; x<HD && y<VD
//  hsync        out  1    registered; HSYNC_POL while HD+HF <= x < HD+HF+HS, else ~HSYNC_POL
//  vsync        out  1    registered; same rule on y with VD/VF/VS/VSYNC_POL
//  vblank       out  1    registered; y >= VD
//  line_start   out  1    1-cycle (clk_100MHz) pulse when x becomes 0
//  frame_start  out  1    1-cycle pulse when (x,y) becomes (0,0)
//  frame_cnt    out  FCW  number of frames started since reset; wraps at 2**FCW
// BEHAVIOUR
//  - Totals and scan order:
//      HTOT=HD+HF+HS+HB, VTOT=VD+VF+VS+VB.
//      Scan order per axis: display, front porch, sync, back porch.
//  - Divider: div counts 0..CLK_DIV-1, advancing only while en=1; wraps to 0 after CLK_DIV-1.
//  - On every clk edge with p_tick=1:
//      x <= (x==HTOT-1) ? 0 : x+1.
//      On x wrap: y <= (y==VTOT-1) ? 0 : y+1.
//  - Output alignment: all derived outputs are computed from the NEXT x/y and registered on the
//    same edge, so x, y, video_on, hsync, vsync and vblank are always mutually consistent.
//    Latency 0 relative to x/y.
//  - Strobes: line_start and frame_start are high exactly the cycle after the updating edge.
//    Both are 0 in all other cycles, including while en=0.
//  - frame_cnt increments on the same edge that raises frame_start.
//  - Reset (async assert, sync release is the caller's job):
//      div=0, x=HTOT-1, y=VTOT-1, video_on=0, vblank=1
//      hsync=~HSYNC_POL, vsync=~VSYNC_POL, strobes 0, frame_cnt=0.
//    The first p_tick therefore wraps to (0,0) and raises frame_start; frame_cnt becomes 1.
//  - en deassert mid-line: all state holds; resumes from the held div/x/y.
//    No partial-pixel loss: div is held, not cleared.
//  - reset_n low mid-frame: immediate return to the reset values above, regardless of en.
//  - Simultaneous line and frame wrap: line_start and frame_start both pulse.
//    y goes VTOT-1 -> 0.
// STRUCTURE
//  - vga_timing_pkg: localparam sets for standard modes (VGA_640x480_60, VGA_640x400_70).
//    Each set is HD/HF/HS/HB/VD/VF/VS/VB plus polarities, and the package also provides a
//    function to compute a total.
//  - Sub-module clk_en_div (CLK_DIV, en -> tick) for the prescaler.
//    All remaining logic (counters, comparators, output registers) lives in this module.
// TESTING
//  1. Reset, CLK_DIV=4, en=1, release:
//     -> x=799, y=524, video_on=0, hsync=vsync=1.
//     -> first p_tick at cycle 4; next cycle x=0, y=0, frame_start=1, frame_cnt=1.
//  2. Horizontal sync window:
//     -> hsync=0 exactly for x=656..751; video_on=1 for x=0..639 on y=0.
//     -> p_tick period is 4 clk cycles.
//  3. Line wrap:
//     -> x 799 -> 0, y 0 -> 1, line_start=1 for one cycle, frame_start=0.
//  4. Frame wrap at (799,524):
//     -> (0,0) with line_start=frame_start=1 and frame_cnt+1.
//     -> vsync=0 only for y=490..491; vblank=1 for y>=480.
//  5. en=0 for 37 cycles at x=100, div=2, then en=1:
//     -> x, div and outputs frozen; p_tick=0 while en=0.
//     -> x=101 after 2 further ticks' worth of clocks, not earlier.
//  6. reset_n pulsed low at (300,200):
//     -> outputs return to reset values immediately, without a clock edge.
//     -> CLK_DIV=1 variant re-run of item 1: p_tick constant 1, x advances every cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Standard raster mode descriptions and a helper that sums one axis into its total period.
package vga_timing_pkg;

    typedef struct packed {
        int   hd;
        int   hf;
        int   hs;
        int   hb;
        int   vd;
        int   vf;
        int   vs;
        int   vb;
        logic hsync_pol;
        logic vsync_pol;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        hd: 640, hf: 16, hs: 96, hb: 48,
        vd: 480, vf: 10, vs: 2,  vb: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    localparam vga_mode_t VGA_640x400_70 = '{
        hd: 640, hf: 16, hs: 96, hb: 48,
        vd: 400, vf: 12, vs: 2,  vb: 35,
        hsync_pol: 1'b0, vsync_pol: 1'b1
    };

    // Axis period: display + front porch + sync + back porch.
    function automatic int axis_total(input int d, input int f, input int s, input int b);
        return d + f + s + b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Pixel prescaler: one-cycle tick every CLK_DIV enabled clocks; the count holds while en=0.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    generate
        if (CLK_DIV < 1) begin : g_div_chk
            $error("clk_en_div: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [DW-1:0] div;

    assign tick = en && (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator running off a pixel clock-enable in the system clock domain.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = 4,
    parameter int   HD        = VGA_640x480_60.hd,
    parameter int   HF        = VGA_640x480_60.hf,
    parameter int   HS        = VGA_640x480_60.hs,
    parameter int   HB        = VGA_640x480_60.hb,
    parameter int   VD        = VGA_640x480_60.vd,
    parameter int   VF        = VGA_640x480_60.vf,
    parameter int   VS        = VGA_640x480_60.vs,
    parameter int   VB        = VGA_640x480_60.vb,
    parameter logic HSYNC_POL = VGA_640x480_60.hsync_pol,
    parameter logic VSYNC_POL = VGA_640x480_60.vsync_pol,
    parameter int   CW        = 10,
    parameter int   FCW       = 16
) (
    input  logic           clk_100MHz,
    input  logic           reset_n,
    input  logic           en,
    output logic           p_tick,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           video_on,
    output logic           hsync,
    output logic           vsync,
    output logic           vblank,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int HTOT = axis_total(HD, HF, HS, HB);
    localparam int VTOT = axis_total(VD, VF, VS, VB);

    generate
        if (HTOT > 2**CW) begin : g_h_chk
            $error("vga_timing_gen: horizontal total does not fit in CW bits");
        end
        if (VTOT > 2**CW) begin : g_v_chk
            $error("vga_timing_gen: vertical total does not fit in CW bits");
        end
    endgenerate

    localparam logic [CW-1:0]  X_LAST = CW'(HTOT - 1);
    localparam logic [CW-1:0]  Y_LAST = CW'(VTOT - 1);
    localparam logic [CW-1:0]  POS_ONE = CW'(1);
    localparam logic [FCW-1:0] FC_ONE  = FCW'(1);

    // One extra bit so window ends equal to 2**CW still compare correctly.
    localparam logic [CW:0] H_DISP     = (CW+1)'(HD);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(HD + HF);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(HD + HF + HS);
    localparam logic [CW:0] V_DISP     = (CW+1)'(VD);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(VD + VF);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(VD + VF + VS);

    clk_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk_100MHz),
        .rst_n(reset_n),
        .en   (en),
        .tick (p_tick)
    );

    logic          x_wrap;
    logic          y_wrap;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic [CW:0]   xe;
    logic [CW:0]   ye;

    always_comb begin
        x_wrap = (x == X_LAST);
        y_wrap = (y == Y_LAST);
        x_nxt  = x_wrap ? '0 : x + POS_ONE;
        y_nxt  = y;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : y + POS_ONE;
        end
        xe = {1'b0, x_nxt};
        ye = {1'b0, y_nxt};
    end

    // Derived outputs are decoded from the next position so they land together with x/y.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            video_on    <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= p_tick && x_wrap;
            frame_start <= p_tick && x_wrap && y_wrap;
            if (p_tick) begin
                x        <= x_nxt;
                y        <= y_nxt;
                video_on <= (xe < H_DISP) && (ye < V_DISP);
                hsync    <= ((xe >= H_SYNC_BEG) && (xe < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
                vsync    <= ((ye >= V_SYNC_BEG) && (ye < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
                vblank   <= (ye >= V_DISP);
                if (x_wrap && y_wrap) begin
                    frame_cnt <= frame_cnt + FC_ONE;
                end
            end
        end
    end

endmodule
